// File: rtl/snell_pkg.sv
// Shared constants and types for the Snell-law datapath stages.
package snell_pkg;

    localparam int XW_DEF    = 7;
    localparam int YW_DEF    = 21;
    localparam int DIV_CONST = 6;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        SUB,
        DONE
    } sin_state_t;

endpackage

// File: rtl/seq_div_const.sv
// Bit-serial restoring divider by DIV_CONST, one quotient bit per cycle, MSB first.
// done is high during the cycle whose clock edge performs the final step.
module seq_div_const
    import snell_pkg::*;
#(
    parameter int OW = 21
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [OW-1:0] operand,
    output logic          done,
    output logic [OW-1:0] quotient
);

    localparam int CW = $clog2(OW);
    localparam logic [3:0] DIVISOR = 4'(DIV_CONST);

    logic [OW-1:0] r_dvd;
    logic [OW-1:0] r_quo;
    logic [2:0]    r_rem;
    logic [CW-1:0] r_cnt;
    logic          r_active;

    logic [3:0]    w_trial;
    logic          w_ge;
    logic [2:0]    w_rem_next;

    // Remainder stays below 6, so it fits in 3 bits; the shifted trial needs 4.
    assign w_trial    = {r_rem, r_dvd[OW-1]};
    assign w_ge       = (w_trial >= DIVISOR);
    assign w_rem_next = w_ge ? 3'(w_trial - DIVISOR) : w_trial[2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_dvd    <= operand;
            r_quo    <= '0;
            r_rem    <= '0;
            r_cnt    <= CW'(OW - 1);
            r_active <= 1'b1;
        end else if (r_active) begin
            r_dvd <= r_dvd << 1;
            r_quo <= {r_quo[OW-2:0], w_ge};
            r_rem <= w_rem_next;
            if (r_cnt == '0) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign done     = r_active && (r_cnt == '0);
    assign quotient = r_quo;

endmodule

// File: rtl/taylor_sin_stage.sv
// Third-order Taylor sine, sin(x) ~ x - x^3/6 in Q0.YW, with a serial divide by 6.
// Define SIN_ROUND_EN to round the x^3/6 term to nearest (ties up) instead of truncating.
module taylor_sin_stage
    import snell_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] cube,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [YW-1:0] sin_q,
    output logic          busy
);

`ifdef SIN_ROUND_EN
    localparam int OW = YW + 1;
`else
    localparam int OW = YW;
`endif

    sin_state_t    r_state;
    sin_state_t    w_state_next;
    logic          w_div_start;
    logic          w_div_done;
    logic [OW-1:0] w_operand;
    logic [OW-1:0] w_quo;
    logic [YW:0]   w_q_ext;
    logic [YW-1:0] w_x_shift;
    logic [YW:0]   w_diff;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_sin_q;

`ifdef SIN_ROUND_EN
    assign w_operand = {1'b0, cube} + OW'(3);
    assign w_q_ext   = w_quo;
`else
    assign w_operand = cube;
    assign w_q_ext   = {1'b0, w_quo};
`endif

    seq_div_const #(
        .OW (OW)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_div_start),
        .operand  (w_operand),
        .done     (w_div_done),
        .quotient (w_quo)
    );

    // Borrow out of the YW+1 bit difference means q > x, which clamps to zero.
    assign w_x_shift = {r_x, {(YW-XW){1'b0}}};
    assign w_diff    = {1'b0, w_x_shift} - w_q_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_div_start  = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_div_start  = 1'b1;
                    w_state_next = DIV;
                end
            end
            DIV: begin
                if (w_div_done) begin
                    w_state_next = SUB;
                end
            end
            SUB: begin
                w_state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x     <= '0;
            r_sin_q <= '0;
        end else begin
            if (w_div_start) begin
                r_x <= x;
            end
            if (r_state == SUB) begin
                r_sin_q <= w_diff[YW] ? '0 : w_diff[YW-1:0];
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sin_q     = r_sin_q;

endmodule

// File: tb/tb_taylor_sin_stage.sv
// Self-checking bench for taylor_sin_stage: directed vectors, stall/reset sequences, random operands.
module tb_taylor_sin_stage;

    localparam int XW = 7;
    localparam int YW = 21;
`ifdef SIN_ROUND_EN
    localparam int RND = 3;
    localparam int LAT = YW + 2;
    localparam int E3  = 49147;
    localparam int E64 = 1004885;
`else
    localparam int RND = 0;
    localparam int LAT = YW + 1;
    localparam int E3  = 49148;
    localparam int E64 = 1004886;
`endif

    typedef struct {
        int unsigned x;
        int unsigned cube;
        int unsigned exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] x;
    logic [YW-1:0] cube;
    logic          out_valid;
    logic          out_ready;
    logic [YW-1:0] sin_q;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    taylor_sin_stage #(.XW(XW), .YW(YW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .cube      (cube),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sin_q     (sin_q),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end else begin
            $display("ok   %s value=%0d", name, act);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // sin ~ x*2^(YW-XW) - (cube+RND)/6, clamped at zero.
    function automatic int unsigned ref_sin(input int unsigned xv, input int unsigned cv);
        longint q;
        longint s;
        q = (longint'(cv) + RND) / 6;
        s = longint'(xv) * (longint'(1) << (YW - XW)) - q;
        return (s < 0) ? 0 : int'(s);
    endfunction

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            tick;
            n++;
        end
    endtask

    task automatic run_op(input int unsigned xv, input int unsigned cv, input int unsigned exp,
                          input string name);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            tick;
            n++;
        end
        check({name, "_ready"}, 32'(in_ready), 1);
        if (!in_ready) return;
        x         = XW'(xv);
        cube      = YW'(cv);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        wait_out(n);
        check({name, "_latency"}, 32'(n), 32'(LAT));
        check({name, "_sin"}, 32'(sin_q), exp);
        tick;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[4];
        int   n;

        vecs[0] = '{x: 3,   cube: 27,      exp: E3};
        vecs[1] = '{x: 64,  cube: 262144,  exp: E64};
        vecs[2] = '{x: 127, cube: 2048383, exp: 1739371};
        vecs[3] = '{x: 0,   cube: 0,       exp: 0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x         = '0;
        cube      = '0;
        tick;
        tick;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sin_q", 32'(sin_q), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick;

        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].x, vecs[i].cube, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Reset in the middle of the division, after a nonzero result is held.
        run_op(127, 2048383, 1739371, "pre_rst");
        x        = 7'd64;
        cube     = 21'd262144;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        check("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        tick;
        check("mid_rst_in_ready", 32'(in_ready), 1);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_sin_q", 32'(sin_q), 0);
        check("mid_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick;
        run_op(0, 0, 0, "post_rst_zero");

        // Output stall with ignored input pulses, then back-to-back accept.
        x         = 7'd64;
        cube      = 21'd262144;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick;
        in_valid = 1'b0;
        wait_out(n);
        check("stall_latency", 32'(n), 32'(LAT));
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 3 == 0);
            x        = 7'd127;
            cube     = 21'd2048383;
            tick;
            check($sformatf("stall%0d_valid", i), 32'(out_valid), 1);
            check($sformatf("stall%0d_sin", i), 32'(sin_q), E64);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        check("release_out_valid", 32'(out_valid), 0);
        check("release_in_ready", 32'(in_ready), 1);
        x        = 7'd3;
        cube     = 21'd27;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        check("b2b_busy", 32'(busy), 1);
        wait_out(n);
        check("b2b_latency", 32'(n), 32'(LAT));
        check("b2b_sin", 32'(sin_q), E3);
        tick;

        run_op(1, 2097151, 0, "saturate");

        for (int i = 0; i < 24; i++) begin
            int unsigned xi;
            int unsigned ci;
            xi = $urandom_range(0, 127);
            ci = (i % 4 == 3) ? $urandom_range(0, (1 << YW) - 1) : xi * xi * xi;
            run_op(xi, ci, ref_sin(xi, ci), $sformatf("rand%0d_x%0d_c%0d", i, xi, ci));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
